// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds FSM encodings, default address bound, port indices and the address check.
package dmem_arbiter_pkg;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    localparam int unsigned ADDR_LIMIT_DEFAULT = 1024;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wd;
    } mreq_t;

    // Word-aligned and strictly below the bound; compared unsigned so 32'hFFFF_FFFC fails.
    function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] limit);
        return (addr < limit) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: a lone eligible port wins,
// on a tie the port that was not served last wins.
module dmem_arbiter_rr_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       last,
    output logic       gnt_vld,
    output logic       winner
);

    always_comb begin
        gnt_vld = |eligible;
        winner  = PORT0;
        case (eligible)
            2'b01:   winner = PORT0;
            2'b10:   winner = PORT1;
            2'b11:   winner = ~last;
            default: winner = PORT0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port req/ack arbiter in front of a single-port data memory; one access per grant,
// ACK two cycles after a valid grant, one cycle after a rejected address.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        P0_REQ,
    input  logic        P0_RW,
    input  logic [31:0] P0_ADDR,
    input  logic [31:0] P0_WD,
    input  logic        P1_REQ,
    input  logic        P1_RW,
    input  logic [31:0] P1_ADDR,
    input  logic [31:0] P1_WD,
    output logic        P0_ACK,
    output logic        P0_ERR,
    output logic [31:0] P0_RD,
    output logic        P1_ACK,
    output logic        P1_ERR,
    output logic [31:0] P1_RD,
    output logic [31:0] M_ADDR,
    output logic        M_RW,
    output logic [31:0] M_WD,
    input  logic [31:0] M_RD,
    output logic        BUSY
);

    localparam logic [31:0] LIMIT = 32'(ADDR_LIMIT);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              win_q, win_d;
    mreq_t             m_q, m_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0]        err_q, err_d;
    logic [1:0][31:0]  rd_q, rd_d;

    logic [1:0] eligible;
    logic       gnt_vld;
    logic       winner;
    mreq_t      win_req;

    // A port whose ACK is high this cycle is still holding its finished request.
    assign eligible = {P1_REQ & ~ack_q[1], P0_REQ & ~ack_q[0]};

    dmem_arbiter_rr_pick2 u_pick (
        .eligible (eligible),
        .last     (last_q),
        .gnt_vld  (gnt_vld),
        .winner   (winner)
    );

    assign win_req = (winner == PORT1) ? mreq_t'{rw: P1_RW, addr: P1_ADDR, wd: P1_WD}
                                       : mreq_t'{rw: P0_RW, addr: P0_ADDR, wd: P0_WD};

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        m_d     = m_q;
        ack_d   = '0;
        err_d   = '0;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    if (addr_ok(win_req.addr, LIMIT)) begin
                        m_d     = win_req;
                        win_d   = winner;
                        state_d = S_ACCESS;
                    end else begin
                        ack_d[winner] = 1'b1;
                        err_d[winner] = 1'b1;
                        last_d        = winner;
                    end
                end
            end
            S_ACCESS: begin
                ack_d[win_q] = 1'b1;
                if (!m_q.rw) begin
                    rd_d[win_q] = M_RD;
                end
                last_d  = win_q;
                m_d     = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            last_q  <= PORT1;
            win_q   <= PORT0;
            m_q     <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            m_q     <= m_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    assign P0_ACK = ack_q[0];
    assign P1_ACK = ack_q[1];
    assign P0_ERR = err_q[0];
    assign P1_ERR = err_q[1];
    assign P0_RD  = rd_q[0];
    assign P1_RD  = rd_q[1];
    assign M_ADDR = m_q.addr;
    assign M_RW   = m_q.rw;
    assign M_WD   = m_q.wd;
    assign BUSY   = (state_q == S_ACCESS);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Cycle-exact directed bench for dmem_arbiter with a 256-word behavioural memory.
module tb_dmem_arbiter;

    localparam logic [31:0] A = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_rw, p1_req, p1_rw;
    logic [31:0] p0_addr, p0_wd, p1_addr, p1_wd;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0] p0_rd, p1_rd;
    logic [31:0] m_addr, m_wd, m_rd;
    logic        m_rw, busy;

    logic [31:0] mem [256];
    logic        mem_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_LIMIT(1024)) dut (
        .CLK(clk), .RST(rst),
        .P0_REQ(p0_req), .P0_RW(p0_rw), .P0_ADDR(p0_addr), .P0_WD(p0_wd),
        .P1_REQ(p1_req), .P1_RW(p1_rw), .P1_ADDR(p1_addr), .P1_WD(p1_wd),
        .P0_ACK(p0_ack), .P0_ERR(p0_err), .P0_RD(p0_rd),
        .P1_ACK(p1_ack), .P1_ERR(p1_err), .P1_RD(p1_rd),
        .M_ADDR(m_addr), .M_RW(m_rw), .M_WD(m_wd), .M_RD(m_rd), .BUSY(busy)
    );

    // Memory: word i preloaded with A+i, write commits on the edge that closes the access.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= A + 32'(i);
            mem_ready <= 1'b1;
        end else if (m_rw && m_addr < 32'd1024) begin
            mem[m_addr[9:2]] <= m_wd;
        end
    end
    assign m_rd = m_rw ? 32'h0 : mem[m_addr[9:2]];

    typedef struct packed {
        logic        rst;
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
    } vin_t;

    typedef struct packed {
        logic        ack0, err0, ack1, err1, busy, mrw;
        logic [31:0] maddr, rd0, rd1;
    } vout_t;

    typedef struct packed {
        vin_t  i;
        vout_t o;
    } vec_t;

    vec_t vecs[$];

    function automatic vin_t vi(logic r, logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
                                logic r1, logic w1, logic [31:0] a1, logic [31:0] d1);
        return '{rst: r, r0: r0, w0: w0, a0: a0, d0: d0, r1: r1, w1: w1, a1: a1, d1: d1};
    endfunction

    function automatic vout_t vo(logic k0, logic e0, logic k1, logic e1, logic b, logic rw,
                                 logic [31:0] ma, logic [31:0] rd0, logic [31:0] rd1);
        return '{ack0: k0, err0: e0, ack1: k1, err1: e1, busy: b, mrw: rw, maddr: ma, rd0: rd0, rd1: rd1};
    endfunction

    function automatic vout_t sample();
        return '{ack0: p0_ack, err0: p0_err, ack1: p1_ack, err1: p1_err, busy: busy, mrw: m_rw,
                 maddr: m_addr, rd0: p0_rd, rd1: p1_rd};
    endfunction

    task automatic drive(input vin_t v);
        rst = v.rst;
        p0_req = v.r0; p0_rw = v.w0; p0_addr = v.a0; p0_wd = v.d0;
        p1_req = v.r1; p1_rw = v.w1; p1_addr = v.a1; p1_wd = v.d1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input vout_t got, input vout_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got ack0=%b err0=%b ack1=%b err1=%b busy=%b mrw=%b maddr=%h rd0=%h rd1=%h ; expected ack0=%b err0=%b ack1=%b err1=%b busy=%b mrw=%b maddr=%h rd0=%h rd1=%h",
                     name, got.ack0, got.err0, got.ack1, got.err1, got.busy, got.mrw, got.maddr, got.rd0, got.rd1,
                     exp.ack0, exp.err0, exp.ack1, exp.err1, exp.busy, exp.mrw, exp.maddr, exp.rd0, exp.rd1);
        end
    endtask

    task automatic chk_word(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        vin_t nop;
        nop = vi(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset, P0 write 8<-42, stale REQ masked, P0 read back
        vecs.push_back({vi(1, 0,0,0,0, 0,0,0,0),        vo(0,0,0,0,0,0,0,     0,     0)});
        vecs.push_back({vi(0, 1,1,8,42, 0,0,0,0),       vo(0,0,0,0,1,1,8,     0,     0)});
        vecs.push_back({vi(0, 1,1,8,42, 0,0,0,0),       vo(1,0,0,0,0,0,0,     0,     0)});
        vecs.push_back({vi(0, 1,1,8,42, 0,0,0,0),       vo(0,0,0,0,0,0,0,     0,     0)});
        vecs.push_back({vi(0, 1,0,8,0, 0,0,0,0),        vo(0,0,0,0,1,0,8,     0,     0)});
        vecs.push_back({vi(0, 1,0,8,0, 0,0,0,0),        vo(1,0,0,0,0,0,0,     42,    0)});
        vecs.push_back({nop,                            vo(0,0,0,0,0,0,0,     42,    0)});
        // tie from reset: P0 first, P1 granted in P0's ACK cycle
        vecs.push_back({vi(1, 0,0,0,0, 0,0,0,0),        vo(0,0,0,0,0,0,0,     0,     0)});
        vecs.push_back({vi(0, 1,0,16,0, 1,0,20,0),      vo(0,0,0,0,1,0,16,    0,     0)});
        vecs.push_back({vi(0, 1,0,16,0, 1,0,20,0),      vo(1,0,0,0,0,0,0,     A+4,   0)});
        vecs.push_back({vi(0, 1,0,16,0, 1,0,20,0),      vo(0,0,0,0,1,0,20,    A+4,   0)});
        vecs.push_back({vi(0, 0,0,0,0, 1,0,20,0),       vo(0,0,1,0,0,0,0,     A+4,   A+5)});
        vecs.push_back({vi(0, 0,0,0,0, 1,0,20,0),       vo(0,0,0,0,0,0,0,     A+4,   A+5)});
        // P0 served alone so it is LAST, then a tie goes to P1
        vecs.push_back({vi(0, 1,0,24,0, 0,0,0,0),       vo(0,0,0,0,1,0,24,    A+4,   A+5)});
        vecs.push_back({vi(0, 1,0,24,0, 0,0,0,0),       vo(1,0,0,0,0,0,0,     A+6,   A+5)});
        vecs.push_back({nop,                            vo(0,0,0,0,0,0,0,     A+6,   A+5)});
        vecs.push_back({vi(0, 1,0,28,0, 1,0,32,0),      vo(0,0,0,0,1,0,32,    A+6,   A+5)});
        vecs.push_back({vi(0, 1,0,28,0, 1,0,32,0),      vo(0,0,1,0,0,0,0,     A+6,   A+8)});
        vecs.push_back({vi(0, 1,0,28,0, 1,0,32,0),      vo(0,0,0,0,1,0,28,    A+6,   A+8)});
        vecs.push_back({vi(0, 1,0,28,0, 0,0,0,0),       vo(1,0,0,0,0,0,0,     A+7,   A+8)});
        vecs.push_back({nop,                            vo(0,0,0,0,0,0,0,     A+7,   A+8)});
        // rejected addresses: ACK+ERR one cycle later, no memory drive
        vecs.push_back({vi(0, 0,0,0,0, 1,1,1024,99),    vo(0,0,1,1,0,0,0,     A+7,   A+8)});
        vecs.push_back({vi(0, 0,0,0,0, 1,1,1024,99),    vo(0,0,0,0,0,0,0,     A+7,   A+8)});
        vecs.push_back({vi(0, 0,0,0,0, 1,1,6,99),       vo(0,0,1,1,0,0,0,     A+7,   A+8)});
        vecs.push_back({nop,                            vo(0,0,0,0,0,0,0,     A+7,   A+8)});
        vecs.push_back({vi(0, 1,1,32'hFFFF_FFFC,5, 0,0,0,0), vo(1,1,0,0,0,0,0, A+7,   A+8)});
        vecs.push_back({nop,                            vo(0,0,0,0,0,0,0,     A+7,   A+8)});
        // highest legal word
        vecs.push_back({vi(0, 0,0,0,0, 1,0,1020,0),     vo(0,0,0,0,1,0,1020,  A+7,   A+8)});
        vecs.push_back({vi(0, 0,0,0,0, 1,0,1020,0),     vo(0,0,1,0,0,0,0,     A+7,   A+255)});
        vecs.push_back({nop,                            vo(0,0,0,0,0,0,0,     A+7,   A+255)});
        // P0 REQ held continuously while stepping through 0, 4, 8
        vecs.push_back({vi(0, 1,0,0,0, 0,0,0,0),        vo(0,0,0,0,1,0,0,     A+7,   A+255)});
        vecs.push_back({vi(0, 1,0,0,0, 0,0,0,0),        vo(1,0,0,0,0,0,0,     A+0,   A+255)});
        vecs.push_back({vi(0, 1,0,4,0, 0,0,0,0),        vo(0,0,0,0,0,0,0,     A+0,   A+255)});
        vecs.push_back({vi(0, 1,0,4,0, 0,0,0,0),        vo(0,0,0,0,1,0,4,     A+0,   A+255)});
        vecs.push_back({vi(0, 1,0,4,0, 0,0,0,0),        vo(1,0,0,0,0,0,0,     A+1,   A+255)});
        vecs.push_back({vi(0, 1,0,8,0, 0,0,0,0),        vo(0,0,0,0,0,0,0,     A+1,   A+255)});
        vecs.push_back({vi(0, 1,0,8,0, 0,0,0,0),        vo(0,0,0,0,1,0,8,     A+1,   A+255)});
        vecs.push_back({vi(0, 1,0,8,0, 0,0,0,0),        vo(1,0,0,0,0,0,0,     42,    A+255)});
        vecs.push_back({nop,                            vo(0,0,0,0,0,0,0,     42,    A+255)});

        drive(vecs[0].i);
        foreach (vecs[k]) begin
            drive(vecs[k].i);
            step();
            chk_out($sformatf("vec%0d", k), sample(), vecs[k].o);
        end

        // rejected writes left memory untouched
        chk_word("mem_word1_after_err", mem[1], A + 1);
        chk_word("mem_word2_after_write", mem[2], 32'd42);

        // RST during a P1 write access: write lands, no ACK, everything back to reset values
        drive(vi(0, 0,0,0,0, 1,1,12,77));
        step();
        chk_out("rst_access_grant", sample(), vo(0,0,0,0,1,1,12, 42, A+255));
        chk_word("rst_access_m_wd", m_wd, 32'd77);
        drive(vi(1, 0,0,0,0, 1,1,12,77));
        step();
        chk_out("rst_access_outputs", sample(), vo(0,0,0,0,0,0,0, 0, 0));
        chk_word("rst_access_m_wd_cleared", m_wd, 32'd0);
        chk_word("rst_access_mem_word3", mem[3], 32'd77);
        drive(nop);
        step();
        chk_out("post_rst_idle", sample(), vo(0,0,0,0,0,0,0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
